// File: rtl/ram_rw_bist.sv
// ram_rw_bist: write/read-back exerciser for a single-port synchronous RAM.
//
// A start pulse accepted in IDLE runs one pass: every address 0..DEPTH-1
// is written with pattern P(addr), then read back in the same order, and
// each returned word is compared RD_LAT cycles after its address was
// presented. Mismatches are counted (saturating). At the end of the pass a
// one-cycle done pulse is raised and pass is updated.
//
// Optional feature macro: RAM_RW_BIST_FIRST_ERR_EN
//   When defined, first_err_addr/first_err_data report the address and the
//   received word of the first mismatch in the pass.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous reset, active-low
//   start          in   one-cycle run request, sampled in IDLE only
//   pattern_sel    in   pattern select, captured when start is accepted
//   ram_rd_data    in   RAM read data
//   ram_en         out  RAM enable
//   ram_we         out  RAM write enable (1=write, 0=read)
//   ram_addr       out  RAM address
//   ram_wr_data    out  RAM write data
//   busy           out  pass in progress
//   done           out  one-cycle end-of-pass pulse
//   err_cnt        out  saturating mismatch count of the last/current pass
//   pass           out  1 iff the last completed pass had no mismatch
//   first_err_addr out  (optional) address of first mismatch
//   first_err_data out  (optional) received data of first mismatch
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | RAM bus quiet, waiting for start
// S_WRITE | writing P(addr) to addr 0..DEPTH-1
// S_READ  | reading addr 0..DEPTH-1, compares trail by RD_LAT cycles
// S_DRAIN | RD_LAT cycles with the bus quiet, collecting the last reads

module ram_rw_bist #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        pattern_sel,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_cnt,
`ifdef RAM_RW_BIST_FIRST_ERR_EN
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
`endif
  output logic              pass
);

  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [LAT_W-1:0]  DRAIN_LOAD = LAT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Pattern generator; the address is zero-extended or truncated to DATA_W.
  function automatic logic [DATA_W-1:0] pat(input logic [1:0] sel,
                                            input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] ax;
    logic [DATA_W-1:0] cb;
    logic [DATA_W-1:0] res;
    ax = DATA_W'(a);
    // ..0101 with bit 0 set; used for even addresses, inverted for odd.
    for (int i = 0; i < DATA_W; i++) cb[i] = ((i % 2) == 0);
    case (sel)
      2'd0:    res = ax;
      2'd1:    res = ~ax;
      2'd2:    res = a[0] ? ~cb : cb;
      default: res = DATA_W'(1) << (32'(a) % DATA_W);
    endcase
    return res;
  endfunction

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [LAT_W-1:0]   drain_q, drain_d;
  logic               en_d, we_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  wd_d;
  logic               busy_d, done_d, pass_d;
  logic [ERR_W-1:0]   err_d;
  logic               accept;
  logic               mismatch;

  // Expected word and valid bit travel alongside each read address so the
  // compare lines up with the RAM's read latency.
  logic               vld_sr [1:RD_LAT];
  logic [DATA_W-1:0]  exp_sr [1:RD_LAT];

  // A start arriving in the done cycle is not taken; the earliest accepted
  // start is the cycle after done.
  assign accept   = (state_q == S_IDLE) && start && !done;
  assign mismatch = vld_sr[RD_LAT] && (ram_rd_data != exp_sr[RD_LAT]);

  always_comb begin
    err_d = err_cnt;
    if (accept) begin
      err_d = '0;
    end else if (mismatch && (err_cnt != {ERR_W{1'b1}})) begin
      err_d = err_cnt + ERR_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    drain_d = drain_q;
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wd_d    = '0;
    busy_d  = busy;
    done_d  = 1'b0;
    pass_d  = pass;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sel_d   = pattern_sel;
          busy_d  = 1'b1;
          en_d    = 1'b1;
          we_d    = 1'b1;
          wd_d    = pat(pattern_sel, '0);
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        en_d = 1'b1;
        if (ram_addr == LAST_ADDR) begin
          state_d = S_READ;
        end else begin
          we_d   = 1'b1;
          addr_d = ram_addr + ADDR_W'(1);
          wd_d   = pat(sel_q, ram_addr + ADDR_W'(1));
        end
      end
      S_READ: begin
        if (ram_addr == LAST_ADDR) begin
          drain_d = DRAIN_LOAD;
          state_d = S_DRAIN;
        end else begin
          en_d   = 1'b1;
          addr_d = ram_addr + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          // The last compare lands in this cycle, so pass uses the
          // updated count.
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_d == '0);
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q - LAT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      drain_q     <= '0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      drain_q     <= drain_d;
      ram_en      <= en_d;
      ram_we      <= we_d;
      ram_addr    <= addr_d;
      ram_wr_data <= wd_d;
      busy        <= busy_d;
      done        <= done_d;
      pass        <= pass_d;
      err_cnt     <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= RD_LAT; i++) begin
        vld_sr[i] <= 1'b0;
        exp_sr[i] <= '0;
      end
    end else begin
      vld_sr[1] <= ram_en && !ram_we;
      exp_sr[1] <= pat(sel_q, ram_addr);
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        exp_sr[i] <= exp_sr[i-1];
      end
    end
  end

`ifdef RAM_RW_BIST_FIRST_ERR_EN
  logic [ADDR_W-1:0] addr_sr [1:RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= RD_LAT; i++) addr_sr[i] <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      addr_sr[1] <= ram_addr;
      for (int i = 2; i <= RD_LAT; i++) addr_sr[i] <= addr_sr[i-1];
      if (accept) begin
        first_err_addr <= '0;
        first_err_data <= '0;
      end else if (mismatch && (err_cnt == '0)) begin
        // err_cnt saturates rather than wrapping, so zero means no
        // mismatch yet in this pass.
        first_err_addr <= addr_sr[RD_LAT];
        first_err_data <= ram_rd_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_rw_bist.sv
module tb_ram_rw_bist;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 24;
  localparam int RD_LAT = 2;
  localparam int ERR_W  = 4;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        pattern_sel = 2'd0;
  logic [DATA_W-1:0] ram_rd_data;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic              busy, done, pass;
  logic [ERR_W-1:0]  err_cnt;

  always #5 clk = ~clk;

  ram_rw_bist #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .RD_LAT(RD_LAT), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern_sel(pattern_sel),
    .ram_rd_data(ram_rd_data), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .busy(busy),
    .done(done), .err_cnt(err_cnt), .pass(pass)
  );

  // Behavioural RAM with read latency and fault injection
  logic [DATA_W-1:0] mem  [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] flip [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_sr [1:RD_LAT];
  bit                stuck0 = 1'b0;

  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wr_data;
    rd_sr[1] <= mem[ram_addr] ^ flip[ram_addr];
    for (int i = 2; i <= RD_LAT; i++) rd_sr[i] <= rd_sr[i-1];
  end
  assign ram_rd_data = stuck0 ? '0 : rd_sr[RD_LAT];

  // Reference pattern, straight from the pattern definitions
  function automatic logic [7:0] ref_pat(input int sel, input int a);
    case (sel)
      0:       return 8'(a);
      1:       return ~8'(a);
      2:       return ((a % 2) == 0) ? 8'h55 : 8'hAA;
      default: return 8'(1 << (a % 8));
    endcase
  endfunction

  int chk_total = 0;
  int chk_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_total++;
    if (act === exp) chk_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic note_fail(input string name, input logic [31:0] act);
    chk_total++;
    $display("FAIL %s: got 0x%0h, nothing expected at t=%0t", name, act, $time);
  endtask

  typedef struct { int addr; logic [7:0] data; } wr_t;
  typedef struct { int err; bit ok; int start_cyc; int done_cyc; } done_t;
  wr_t   wr_q [$];
  int    rd_q [$];
  done_t done_q [$];

  int cyc = 0;
  int done_seen = 0;
  int last_err = 0;
  bit last_ok = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations as the DUT presents bus cycles and done
  wr_t   mw;
  int    mr;
  done_t md;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_en && ram_we) begin
        if (wr_q.size() == 0) note_fail("wr_unexpected", 32'(ram_addr));
        else begin
          mw = wr_q.pop_front();
          check("wr_addr", 32'(ram_addr), 32'(mw.addr));
          check("wr_data", 32'(ram_wr_data), 32'(mw.data));
        end
      end else if (ram_en) begin
        if (rd_q.size() == 0) note_fail("rd_unexpected", 32'(ram_addr));
        else begin
          mr = rd_q.pop_front();
          check("rd_addr", 32'(ram_addr), 32'(mr));
          check("rd_wdata_zero", 32'(ram_wr_data), 32'h0);
        end
      end else begin
        check("bus_quiet", 32'({ram_we, ram_addr, ram_wr_data}), 32'h0);
      end
      if (done_q.size() > 0)
        check("busy", 32'(busy), 32'(cyc >= done_q[0].start_cyc && cyc < done_q[0].done_cyc));
      else
        check("busy_idle", 32'(busy), 32'h0);
      if (done) begin
        done_seen++;
        if (done_q.size() == 0) note_fail("done_unexpected", 32'(err_cnt));
        else begin
          md = done_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(md.done_cyc));
          check("err_cnt", 32'(err_cnt), 32'(md.err));
          check("pass", 32'(pass), 32'(md.ok));
        end
      end
    end
  end

  task automatic clear_faults();
    for (int a = 0; a < (1 << ADDR_W); a++) flip[a] = '0;
    stuck0 = 1'b0;
  endtask

  // Pushes the expected bus traffic and end-of-pass result, then pulses start.
  task automatic issue_start(input int sel);
    int cnt;
    logic [7:0] obs;
    done_t d;
    @(posedge clk); #1;
    cnt = 0;
    for (int a = 0; a < DEPTH; a++) begin
      wr_q.push_back('{addr: a, data: ref_pat(sel, a)});
      rd_q.push_back(a);
      obs = stuck0 ? 8'h00 : (ref_pat(sel, a) ^ flip[a]);
      if (obs != ref_pat(sel, a)) cnt++;
    end
    d.err       = (cnt > ERR_MAX) ? ERR_MAX : cnt;
    d.ok        = (cnt == 0);
    d.start_cyc = cyc + 1;
    d.done_cyc  = cyc + 1 + 2*DEPTH + RD_LAT;
    done_q.push_back(d);
    last_err = d.err;
    last_ok  = d.ok;
    start = 1'b1;
    pattern_sel = 2'(sel);
    @(posedge clk); #1;
    start = 1'b0;
    pattern_sel = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done();
    int s;
    int n;
    s = done_seen;
    n = 0;
    while (done_seen == s && n < 3*DEPTH + 20) begin
      @(posedge clk);
      n++;
    end
    if (done_seen == s) note_fail("done_timeout", 32'(n));
    @(negedge clk);
    check("wr_q_drained", 32'(wr_q.size()), 32'h0);
    check("rd_q_drained", 32'(rd_q.size()), 32'h0);
  endtask

  task automatic run_pass(input int sel);
    issue_start(sel);
    wait_done();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("err_hold", 32'(err_cnt), 32'(last_err));
    check("pass_hold", 32'(pass), 32'(last_ok));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bus"}, 32'({ram_en, ram_we, ram_addr, ram_wr_data}), 32'h0);
    check({tag, "_busy_done"}, 32'({busy, done}), 32'h0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'h0);
    check({tag, "_pass"}, 32'(pass), 32'h0);
  endtask

  initial begin
    int s;
    clear_faults();
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = '0;
    for (int i = 1; i <= RD_LAT; i++) rd_sr[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Clean incrementing pass
    run_pass(0);
    // Checkerboard, bit 0 flipped on the word read from address 5
    flip[5] = 8'h01;
    run_pass(2);
    clear_faults();
    // Walking one, clean
    run_pass(3);
    // Read data stuck at zero: count must saturate
    stuck0 = 1'b1;
    run_pass(1);
    clear_faults();

    // Randomised patterns and fault sets
    for (int it = 0; it < 6; it++) begin
      int nf;
      clear_faults();
      nf = $urandom_range(0, 4);
      for (int k = 0; k < nf; k++)
        flip[$urandom_range(0, DEPTH-1)] = 8'(1 << $urandom_range(0, 7));
      stuck0 = ($urandom_range(0, 5) == 0);
      run_pass($urandom_range(0, 3));
    end
    clear_faults();

    // Start re-pulsed while busy is ignored: one pass, one done
    s = done_seen;
    issue_start(0);
    repeat (8) @(posedge clk); #1;
    start = 1'b1;
    pattern_sel = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (2*DEPTH + 10) @(posedge clk);
    check("single_done", 32'(done_seen), 32'(s + 1));

    // Reset in the middle of a pass
    issue_start(2);
    repeat (38) @(posedge clk); #1;
    rst_n = 1'b0;
    wr_q.delete();
    rd_q.delete();
    done_q.delete();
    @(negedge clk);
    check_all_zero("midreset");
    s = done_seen;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2*DEPTH + 10) @(posedge clk);
    check("no_done_after_reset", 32'(done_seen), 32'(s));
    run_pass(0);

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", chk_pass, chk_total);
    $fatal(1);
  end
endmodule
